// File: rtl/b14_bus_responder.sv
// Memory-side responder for the b14 bus: word RAM, RD_LAT-deep read pipeline, bench preload port.
// Define B14_RESP_WRLOG_EN to build the last-write capture registers.
module b14_bus_responder #(
   parameter int unsigned DEPTH_LOG2 = 5,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [19:0]           addr,
   input  logic [30:0]           datao,
   input  logic                  rd,
   input  logic                  wr,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [30:0]           ld_data,
   output logic [30:0]           datai,
   output logic                  rd_vld,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count,
   output logic                  oob_err,
   output logic [19:0]           last_wr_addr,
   output logic [30:0]           last_wr_data
);

   localparam int unsigned Words = 2 ** DEPTH_LOG2;

   logic [30:0]           mem [Words];
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  issue;
   logic [30:0]           issue_data;
   logic                  wr_commit;
   logic                  oob_hit;
   logic                  fin_vld;
   logic [30:0]           fin_data;

   assign in_range   = (addr >> DEPTH_LOG2) == 20'd0;
   assign idx        = addr[DEPTH_LOG2-1:0];
   assign issue      = rd & ~reset;
   // Combinational RAM read gives read-before-write ordering at the sampling edge.
   assign issue_data = in_range ? mem[idx] : 31'h0;
   assign wr_commit  = wr & in_range & ~ld_en & ~reset;
   assign oob_hit    = ~reset & ~in_range & (rd | (wr & ~ld_en));

   // Preload wins over a bus write and ignores reset; RAM is never cleared.
   always_ff @(posedge clock) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (wr_commit) begin
         mem[idx] <= datao;
      end
   end

   if (RD_LAT > 1) begin : g_pipe
      logic [RD_LAT-2:0] vld_q;
      logic [30:0]       data_q [RD_LAT-1];

      always_ff @(posedge clock) begin
         if (reset) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      always_ff @(posedge clock) begin
         data_q[0] <= issue_data;
         for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
            data_q[i] <= data_q[i-1];
         end
      end

      assign fin_vld  = vld_q[RD_LAT-2];
      assign fin_data = data_q[RD_LAT-2];
   end else begin : g_direct
      assign fin_vld  = issue;
      assign fin_data = issue_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         datai    <= 31'h0;
         rd_vld   <= 1'b0;
         rd_count <= 16'h0;
         wr_count <= 16'h0;
         oob_err  <= 1'b0;
      end else begin
         rd_vld <= fin_vld;
         if (fin_vld) begin
            datai <= fin_data;
         end
         if (issue && rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
         end
         if (wr_commit && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
         end
         if (oob_hit) begin
            oob_err <= 1'b1;
         end
      end
   end

`ifdef B14_RESP_WRLOG_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         last_wr_addr <= 20'h0;
         last_wr_data <= 31'h0;
      end else if (wr_commit) begin
         last_wr_addr <= addr;
         last_wr_data <= datao;
      end
   end
`else
   assign last_wr_addr = 20'h0;
   assign last_wr_data = 31'h0;
`endif

endmodule
